// File: rtl/ram_dp_param.sv
// ram_dp_param: parameterised simple dual-port RAM (one write port, one read
// port, one clock) with byte enables, selectable read-during-write policy,
// optional output register and a zero-fill clear engine.
module ram_dp_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   d_in,
    input  logic [DATA_W/8-1:0] be,
    input  logic                re,
    input  logic [ADDR_W-1:0]   re_addr,
    input  logic                clr,
    output logic [DATA_W-1:0]   d_out,
    output logic                d_valid,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [DATA_W-1:0]   w_rd_word;

    // clr wins over a same-cycle user access; nothing is accepted while clearing
    assign w_wr_acc = !r_busy && wr && !clr;
    assign w_rd_acc = !r_busy && re && !clr;
    assign busy     = r_busy;

    // Clear engine FSM: sweeps the counter over every address, then idles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (clr) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage array: zero-fill while clearing, otherwise byte-enabled writes.
    // Deliberately not reset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (r_busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) r_mem[wr_addr][i*8 +: 8] <= d_in[i*8 +: 8];
            end
        end
    end

    // Read word with optional byte-merged bypass for same-address collisions
    always_comb begin
        w_rd_word = r_mem[re_addr];
        if (RDW_MODE != 0 && w_wr_acc && wr_addr == re_addr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) w_rd_word[i*8 +: 8] = d_in[i*8 +: 8];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r_s1_data;
            logic              r_s1_vld;

            // First read stage: capture array word for accepted reads
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_s1_data <= '0;
                    r_s1_vld  <= 1'b0;
                end else begin
                    r_s1_vld <= w_rd_acc;
                    if (w_rd_acc) r_s1_data <= w_rd_word;
                end
            end

            // Output stage: d_out only moves when a valid word arrives
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    d_out   <= '0;
                    d_valid <= 1'b0;
                end else begin
                    d_valid <= r_s1_vld;
                    if (r_s1_vld) d_out <= r_s1_data;
                end
            end
        end else begin : g_noreg
            // Single read stage: d_out only moves on an accepted read
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    d_out   <= '0;
                    d_valid <= 1'b0;
                end else begin
                    d_valid <= w_rd_acc;
                    if (w_rd_acc) d_out <= w_rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: two instances share stimulus.
//   A: DATA_W=8,  OUT_REG=0, RDW_MODE=0 (old data on collision)
//   B: DATA_W=32, OUT_REG=1, RDW_MODE=1 (merged data on collision)
// Expected read results are queued with their due cycle and checked by a
// negedge monitor; busy/clear timing is checked inline.
module tb_ram_dp_param;

    typedef struct {
        logic [31:0] d;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0, re = 1'b0, clr = 1'b0;
    logic [3:0]  wr_addr = '0, re_addr = '0, be = '0;
    logic [31:0] d_in = '0;

    logic [7:0]  a_dout;
    logic        a_dv, a_busy;
    logic [31:0] b_dout;
    logic        b_dv, b_busy;

    int          tests = 0, fails = 0, cyc = 0;
    bit          run = 0, m_idle = 0;
    exp_t        qa[$], qb[$];
    exp_t        ea, eb;
    logic [7:0]  a_last = '0;
    logic [31:0] b_last = '0;
    logic [7:0]  ma [16];
    logic [31:0] mb [16];

    ram_dp_param #(.DATA_W(8), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0)) u_a (
        .clk(clk), .rst(rst), .wr(wr), .wr_addr(wr_addr), .d_in(d_in[7:0]),
        .be(be[0:0]), .re(re), .re_addr(re_addr), .clr(clr),
        .d_out(a_dout), .d_valid(a_dv), .busy(a_busy));

    ram_dp_param #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(1)) u_b (
        .clk(clk), .rst(rst), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .be(be), .re(re), .re_addr(re_addr), .clr(clr),
        .d_out(b_dout), .d_valid(b_dv), .busy(b_busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_models();
        for (int i = 0; i < 16; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
    endtask

    // One cycle of stimulus; queues expected reads and updates the models
    task automatic drive(input logic w, input logic [3:0] wa, input logic [31:0] din,
                         input logic [3:0] b, input logic r, input logic [3:0] ra,
                         input logic c);
        exp_t x;
        wr = w; wr_addr = wa; d_in = din; be = b; re = r; re_addr = ra; clr = c;
        if (m_idle && !c) begin
            if (r) begin
                x.d = 32'(ma[ra]); x.cyc = cyc + 1;
                qa.push_back(x);
                x.d = mb[ra];
                if (w && wa == ra)
                    for (int i = 0; i < 4; i++) if (b[i]) x.d[i*8 +: 8] = din[i*8 +: 8];
                x.cyc = cyc + 2;
                qb.push_back(x);
            end
            if (w) begin
                for (int i = 0; i < 4; i++) if (b[i]) mb[wa][i*8 +: 8] = din[i*8 +: 8];
                if (b[0]) ma[wa] = din[7:0];
            end
        end
        if (m_idle && c) begin
            zero_models();
            m_idle = 0;
        end
        tick();
        wr = 0; re = 0; clr = 0;
    endtask

    // Counts busy cycles from the current point until busy drops (bounded)
    task automatic wait_clear();
        int n = 0;
        while (a_busy && n < 40) begin
            tick();
            n++;
            check("busy_match", b_busy, a_busy);
        end
        check("clear_len", n, 16);
        m_idle = 1;
    endtask

    // Read-result scoreboard plus hold / no-spurious-valid checks
    always @(negedge clk) begin
        if (!rst) begin
            a_last = '0;
            b_last = '0;
            check("a_rst_dout", a_dout, 0);
            check("a_rst_dv", a_dv, 0);
            check("b_rst_dout", b_dout, 0);
            check("b_rst_dv", b_dv, 0);
        end else if (run) begin
            if (qa.size() > 0 && qa[0].cyc == cyc) begin
                ea = qa.pop_front();
                check("a_dv", a_dv, 1);
                check("a_dout", a_dout, ea.d);
                a_last = ea.d[7:0];
            end else begin
                check("a_dv_idle", a_dv, 0);
                check("a_hold", a_dout, a_last);
            end
            if (qb.size() > 0 && qb[0].cyc == cyc) begin
                eb = qb.pop_front();
                check("b_dv", b_dv, 1);
                check("b_dout", b_dout, eb.d);
                b_last = eb.d;
            end else begin
                check("b_dv_idle", b_dv, 0);
                check("b_hold", b_dout, b_last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t2a[4] = '{11, 9, 10, 3};
        int t2d[4] = '{'h24, 'h81, 'h09, 'h63};

        zero_models();
        #1 rst = 0;
        repeat (3) tick();
        check("rst_busy_a", a_busy, 1);
        check("rst_busy_b", b_busy, 1);
        run = 1;

        // Clear after reset, then every word reads zero
        rst = 1;
        wait_clear();
        for (int a = 0; a < 16; a++) drive(0, 0, 0, 0, 1, 4'(a), 0);

        // Basic write / read
        for (int i = 0; i < 4; i++)
            drive(1, 4'(t2a[i]), 32'hA5000000 | 32'(t2d[i]), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 4'(t2a[i]), 0);

        // Byte enables
        drive(1, 4'h5, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        drive(1, 4'h5, 32'h11223344, 4'h5, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 4'h5, 0);

        // Same-address collision, then follow-up read
        drive(1, 4'h7, 32'h0000003C, 4'hF, 0, 0, 0);
        drive(1, 4'h7, 32'h556677C3, 4'h3, 1, 4'h7, 0);
        drive(0, 0, 0, 0, 1, 4'h7, 0);

        // Write then read one cycle later; independent different-address access
        drive(1, 4'h8, 32'hDEADBE9A, 4'hF, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 4'h8, 0);
        drive(1, 4'h9, 32'h13579BDF, 4'hF, 1, 4'h3, 0);
        drive(0, 0, 0, 0, 1, 4'h9, 0);

        // clr in IDLE: read just before clr completes, write with clr dropped,
        // read during busy yields nothing
        for (int a = 0; a < 16; a++) drive(1, 4'(a), 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 4'h4, 0);
        drive(1, 4'h2, 32'h00000055, 4'hF, 0, 0, 1);
        re = 1; re_addr = 4'h2;
        wait_clear();
        re = 0;
        for (int a = 0; a < 16; a++) drive(0, 0, 0, 0, 1, 4'(a), 0);

        // Reset mid-read: pending valids are discarded
        drive(1, 4'h1, 32'h0000005A, 4'hF, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 4'h1, 0);
        drive(0, 0, 0, 0, 1, 4'h1, 0);
        rst = 0;
        qa.delete(); qb.delete();
        m_idle = 0;
        zero_models();
        tick(); tick();
        check("rst_read_busy", a_busy, 1);
        rst = 1;
        wait_clear();
        drive(0, 0, 0, 0, 1, 4'h1, 0);

        // Reset mid-clear: clear restarts and runs the full length
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("midclr_busy", a_busy, 1);
        end
        rst = 0;
        tick(); tick();
        check("rst_clr_busy_a", a_busy, 1);
        check("rst_clr_busy_b", b_busy, 1);
        rst = 1;
        wait_clear();
        for (int a = 0; a < 16; a++) drive(0, 0, 0, 0, 1, 4'(a), 0);

        repeat (4) tick();
        check("a_drain", qa.size(), 0);
        check("b_drain", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised simple dual-port RAM: one write port, one read port, one clock, sized by parameters. It replaces the fixed 16x8 dual-port RAM as the team's generic on-chip storage primitive. It adds:
- byte-enable writes;
- a selectable read-during-write collision policy;
- an optional output register stage with a read-valid flag;
- a hardware clear engine that zero-fills the array after reset or on request.

## Interface
Parameters:
- DATA_W, default 8: data width in bits; must be a multiple of 8.
- ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.
- OUT_REG, default 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- RDW_MODE, default 0: same-address read during write returns 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- d_in  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit i gates d_in[8i+7:8i].
- re  in  1  read strobe.
- re_addr  in  ADDR_W  read address.
- clr  in  1  single-cycle request to zero-fill the array.
- d_out  out  DATA_W  read data; holds last value between reads.
- d_valid  out  1  high for one cycle when d_out carries data for an accepted read.
- busy  out  1  clear engine active; user accesses are ignored.

## Operation
State machine: CLEAR, IDLE.

While rst is low:
- state = CLEAR, clear address counter = 0, busy = 1, d_out = 0, d_valid = 0, pipeline registers = 0.
- Array contents are not reset asynchronously.

CLEAR:
- Each cycle, write 0 to all bytes at the counter address, then increment the counter.
- After address DEPTH-1 is written, go to IDLE; busy falls on the same edge.
- wr, re and clr are ignored. d_valid stays 0. d_out holds.

IDLE:
- wr=1 (accepted): for every byte i with be[i]=1, mem[wr_addr] byte i takes d_in byte i. Bytes with be[i]=0 are unchanged. wr with be=0 is a no-op.
- re=1 (accepted): read mem[re_addr]. Result appears on d_out with d_valid=1 after the read latency.
- clr=1: enter CLEAR on the next edge with counter = 0 and busy = 1. A wr or re in the same cycle is dropped; clr has priority.
- A read accepted the cycle before clr still completes normally through the pipeline.

Read-during-write (wr and re both accepted, wr_addr == re_addr):
- RDW_MODE=0: returned word is the pre-write contents.
- RDW_MODE=1: returned word is the pre-write word with the enabled bytes replaced by d_in (byte-merged bypass).
- When addresses differ, the two accesses are independent.

Reset mid-clear or mid-read:
- Aborts the operation. Pending d_valid is discarded.
- After reset releases, the clear restarts from address 0.

## Timing
- Clear duration: exactly DEPTH cycles, counted from the first rising edge after rst releases (or after clr is sampled). busy is high for those DEPTH cycles.
- Read latency, OUT_REG=0: re sampled at edge N gives d_out/d_valid valid after edge N+1.
- Read latency, OUT_REG=1: valid after edge N+2.
- Reads are fully pipelined: one accepted read per cycle gives one d_valid per cycle.
- Write is visible to a read on a different cycle starting from the edge after the write.
- Back-to-back write then read of the same address (read one cycle later) returns the new data in either RDW_MODE.
- d_valid is a one-cycle pulse per accepted read, never asserted without one.
- d_out changes only when d_valid is asserted or on reset.

## Test plan
Defaults unless stated (DATA_W=8, ADDR_W=4, OUT_REG=0, RDW_MODE=0).

1. Clear after reset: release rst, then read addresses 0..15 once busy falls.
   -> busy high for exactly 16 cycles; all 16 reads return 0x00 with d_valid.
2. Basic write/read: write 0x24 to 0xB, 0x81 to 0x9, 0x09 to 0xA, 0x63 to 0x3, then read each address.
   -> same values in order, d_valid one cycle after each re (two cycles with OUT_REG=1).
3. Byte enables (DATA_W=32): write 0xAABBCCDD with be=4'b1111 to 0x5, then 0x11223344 with be=4'b0101 to 0x5, then read 0x5.
   -> 0xAA22CC44.
4. Collision (DATA_W=8): mem[0x7]=0x3C; assert wr 0x7 = 0xC3 with re 0x7 in the same cycle.
   -> returns 0x3C with RDW_MODE=0, 0xC3 with RDW_MODE=1. A following read returns 0xC3 in both modes.
5. clr in IDLE: fill 0x0..0xF with 0xFF; pulse clr together with wr 0x2 = 0x55.
   -> write dropped; busy high for 16 cycles; all reads return 0x00. A re asserted during busy produces no d_valid.
6. Reset mid-clear: assert rst for 2 cycles at clear cycle 8.
   -> busy stays high; the full 16-cycle clear restarts from address 0; d_out = 0 and d_valid = 0 during reset.
